// File: rtl/morse_keyer.sv
// Morse keyer: queues 2-bit symbol codes in a FIFO and keys them onto a serial
// line with standard unit timing (dot 1U, dash 3U, element gap 1U, letter 3U, word 7U).
module morse_keyer #(
  parameter int unsigned UNIT_CYCLES = 50000000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    sym_in,
  input  logic                          sym_valid,
  output logic                          sym_ready,
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CW   = $clog2(UNIT_CYCLES);
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = PW + 1;

  localparam logic [CW-1:0]   UNIT_LAST = CW'(UNIT_CYCLES - 1);
  localparam logic [CNTW-1:0] FULL      = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  typedef struct packed {
    state_t     st;
    logic [2:0] rem;
  } load_t;

  state_t          state_q, state_d;
  logic [2:0]      rem_q, rem_d;
  logic [CW-1:0]   ucnt_q, ucnt_d;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic [1:0]      mem_q [FIFO_DEPTH];
  logic            serial_q, busy_q;

  logic       push, pop, unit_tick, fifo_nempty;
  logic [1:0] head;
  load_t      ld;

  function automatic load_t load_sym(input logic [1:0] code);
    load_t r;
    case (code)
      2'b01:   begin r.st = MARK;  r.rem = 3'd1; end
      2'b11:   begin r.st = MARK;  r.rem = 3'd3; end
      2'b10:   begin r.st = SPACE; r.rem = 3'd2; end
      default: begin r.st = SPACE; r.rem = 3'd6; end
    endcase
    return r;
  endfunction

  assign sym_ready   = (count_q != FULL);
  assign push        = sym_valid & sym_ready;
  assign fifo_nempty = (count_q != '0);
  assign head        = mem_q[rptr_q];
  assign ld          = load_sym(head);
  assign unit_tick   = (ucnt_q == UNIT_LAST);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_nempty) begin
          pop     = 1'b1;
          state_d = ld.st;
          rem_d   = ld.rem;
        end
      end
      MARK: begin
        if (unit_tick) begin
          if (rem_q == 3'd1) begin
            state_d = SPACE;
            rem_d   = 3'd1;
          end else begin
            rem_d = rem_q - 3'd1;
          end
        end
      end
      SPACE: begin
        if (unit_tick) begin
          if (rem_q == 3'd1) begin
            // Chain straight into the next symbol so no idle cycle appears on the line.
            if (fifo_nempty) begin
              pop     = 1'b1;
              state_d = ld.st;
              rem_d   = ld.rem;
            end else begin
              state_d = IDLE;
              rem_d   = '0;
            end
          end else begin
            rem_d = rem_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_comb begin
    ucnt_d = ucnt_q + 1'b1;
    if (state_d == IDLE || pop || unit_tick) begin
      ucnt_d = '0;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= sym_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      ucnt_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      serial_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      ucnt_q   <= ucnt_d;
      wptr_q   <= push ? wptr_q + 1'b1 : wptr_q;
      rptr_q   <= pop  ? rptr_q + 1'b1 : rptr_q;
      count_q  <= count_d;
      // Line and busy follow the FSM by one cycle, keeping them aligned with each other.
      serial_q <= (state_q == MARK);
      busy_q   <= (state_q != IDLE) | fifo_nempty;
    end
  end

  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: a symbol-to-waveform model checked every cycle, plus
// hand-computed run lengths and a mark-length decoder standing in for the detector.
module tb_morse_keyer;
  localparam int unsigned U  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    sym_in = 2'b00;
  logic          sym_valid = 1'b0;
  logic          sym_ready, serial_out, busy;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  morse_keyer #(.UNIT_CYCLES(U), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .serial_out (serial_out),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  int checks = 0;
  int errors = 0;

  // Model: pending codes, plus the line waveform still owed by the current symbol.
  logic [1:0] fq[$];
  bit         wave[$];
  bit         m_serial = 1'b0;
  bit         m_busy   = 1'b0;

  // Run-length tracker on the observed line.
  int marks[$];
  int spaces[$];
  bit prev_s = 1'b0;
  bit seen_mark = 1'b0;
  int hi_len = 0;
  int lo_len = 0;
  bit saw_full = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_bits(input bit v, input int n);
    for (int i = 0; i < n; i++) wave.push_back(v);
  endtask

  task automatic expand(input logic [1:0] c);
    case (c)
      2'b01:   begin add_bits(1'b1, U);     add_bits(1'b0, U); end
      2'b11:   begin add_bits(1'b1, 3 * U); add_bits(1'b0, U); end
      2'b10:   add_bits(1'b0, 2 * U);
      default: add_bits(1'b0, 6 * U);
    endcase
  endtask

  task automatic model_step();
    int pre_f;
    if (rst) begin
      fq.delete();
      wave.delete();
      m_serial = 1'b0;
      m_busy   = 1'b0;
    end else begin
      pre_f    = fq.size();
      m_busy   = (wave.size() != 0) || (pre_f != 0);
      m_serial = (wave.size() != 0) ? wave[0] : 1'b0;
      if (wave.size() != 0) void'(wave.pop_front());
      if (wave.size() == 0 && pre_f != 0) expand(fq.pop_front());
      if (sym_valid && pre_f != int'(D)) fq.push_back(sym_in);
    end
  endtask

  task automatic compare();
    chk("serial_out", int'(serial_out), int'(m_serial));
    chk("busy", int'(busy), int'(m_busy));
    chk("fifo_count", int'(fifo_count), fq.size());
    chk("sym_ready", int'(sym_ready), int'(fq.size() != int'(D)));
  endtask

  task automatic track();
    if (serial_out) begin
      if (!prev_s) begin
        if (seen_mark) spaces.push_back(lo_len);
        hi_len = 0;
      end
      hi_len++;
    end else begin
      if (prev_s) begin
        marks.push_back(hi_len);
        seen_mark = 1'b1;
        lo_len = 0;
      end
      lo_len++;
    end
    prev_s = serial_out;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    track();
  endtask

  task automatic clear_runs();
    marks.delete();
    spaces.delete();
    seen_mark = 1'b0;
    prev_s = serial_out;
    hi_len = 0;
    lo_len = 0;
  endtask

  task automatic push(input logic [1:0] c);
    bit a;
    bit done;
    done = 1'b0;
    sym_in = c;
    sym_valid = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      a = sym_ready;
      if (!a) saw_full = 1'b1;
      cyc();
      if (a) done = 1'b1;
    end
    sym_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 3000 && !done; i++) begin
      if (!busy && fifo_count == '0) done = 1'b1;
      else cyc();
    end
    if (!done) chk("idle_timeout", 0, 1);
    for (int i = 0; i < 3; i++) cyc();
  endtask

  task automatic chk_runs(input string name, input int em[$], input int es[$]);
    chk({name, "_nmarks"}, marks.size(), em.size());
    chk({name, "_nspaces"}, spaces.size(), es.size());
    for (int i = 0; i < em.size() && i < marks.size(); i++) chk({name, "_mark"}, marks[i], em[i]);
    for (int i = 0; i < es.size() && i < spaces.size(); i++) chk({name, "_space"}, spaces[i], es[i]);
  endtask

  initial begin
    int         em[$];
    int         es[$];
    int         sent[$];
    int         dec;
    logic [11:0] exp_ser;
    logic [11:0] exp_busy;

    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_serial", int'(serial_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ready", int'(sym_ready), 1);
    rst = 1'b0;
    cyc();

    // Single dot from idle: line high on edges N+2..N+5, busy N+1..N+9.
    clear_runs();
    exp_ser  = 12'h03C;
    exp_busy = 12'h3FE;
    push(2'b01);
    chk("dot_count_after_push", int'(fifo_count), 1);
    for (int i = 0; i < 12; i++) begin
      chk("dot_serial_lit", int'(serial_out), int'(exp_ser[i]));
      chk("dot_busy_lit", int'(busy), int'(exp_busy[i]));
      cyc();
    end
    wait_idle();

    clear_runs();
    push(2'b11);
    push(2'b01);
    wait_idle();
    em = {12, 4}; es = {4};
    chk_runs("dash_dot", em, es);
    chk("dash_dot_count", int'(fifo_count), 0);

    clear_runs();
    push(2'b01);
    push(2'b10);
    push(2'b01);
    wait_idle();
    em = {4, 4}; es = {12};
    chk_runs("letter_gap", em, es);

    clear_runs();
    push(2'b01);
    push(2'b00);
    push(2'b01);
    wait_idle();
    em = {4, 4}; es = {28};
    chk_runs("word_gap", em, es);

    // Fill the FIFO with valid held high, then decode marks back to codes.
    clear_runs();
    saw_full = 1'b0;
    sent.delete();
    for (int k = 0; k < 8; k++) begin
      sent.push_back((k % 2 == 0) ? 3 : 1);
      push((k % 2 == 0) ? 2'b11 : 2'b01);
    end
    wait_idle();
    chk("fill_saw_full", int'(saw_full), 1);
    chk("loop_nsyms", marks.size(), 8);
    for (int i = 0; i < 8 && i < marks.size(); i++) begin
      dec = (marks[i] == int'(U)) ? 1 : (marks[i] == int'(3 * U)) ? 3 : -1;
      chk("loop_code", dec, sent[i]);
    end
    em = {12, 4, 12, 4, 12, 4, 12, 4}; es = {4, 4, 4, 4, 4, 4, 4};
    chk_runs("fill", em, es);

    // Reset in the middle of a dash with three more queued.
    push(2'b11);
    push(2'b11);
    push(2'b11);
    push(2'b11);
    cyc();
    cyc();
    cyc();
    chk("mid_count", int'(fifo_count), 3);
    chk("mid_serial", int'(serial_out), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_serial", int'(serial_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_ready", int'(sym_ready), 1);
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("no_resume_serial", int'(serial_out), 0);
      chk("no_resume_busy", int'(busy), 0);
    end
    clear_runs();
    push(2'b01);
    wait_idle();
    em = {4}; es = {};
    chk_runs("after_rst", em, es);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
